// File: rtl/pwm_pkg.sv
// Shared register map and CTRL bit positions for the PWM bus slave.
package pwm_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_CNT    = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 1;

endpackage

// File: rtl/pwm_slave_if.sv
// Configuration bus between the sequencer (master) and the PWM peripheral (slave).
// cs qualifies wr/rd; a write lands on the clock edge, read data is valid the cycle after rd.
interface pwm_slave_if;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [31:0] adr;
  logic [31:0] d_in;
  logic [31:0] d_out;

  modport master (output cs, output wr, output rd, output adr, output d_in, input d_out);
  modport slave  (input cs, input wr, input rd, input adr, input d_in, output d_out);
endinterface

// File: rtl/pwm_core.sv
// Free-running period counter with active period/duty registers reloaded at each wrap.
module pwm_core #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_period_sh,
  input  logic [CNT_W-1:0] i_duty_sh,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_pwm,
  output logic             o_period_tick,
  output logic             o_load
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_act;
  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;
  logic             r_tick;
  logic             w_wrap;

  // Periods of 0 and 1 wrap every cycle; guard avoids the period-1 underflow at 0.
  always_comb begin
    w_wrap = (r_period_act < CNT_W'(2)) || (r_cnt >= (r_period_act - CNT_W'(1)));
  end

  assign o_load = !i_en || w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_period_act <= '0;
      r_duty_act   <= '0;
      r_pwm        <= 1'b0;
      r_tick       <= 1'b0;
    end else if (!i_en) begin
      r_cnt        <= '0;
      r_period_act <= i_period_sh;
      r_duty_act   <= i_duty_sh;
      r_pwm        <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_pwm <= (r_cnt < r_duty_act);
      if (w_wrap) begin
        r_cnt        <= '0;
        r_period_act <= i_period_sh;
        r_duty_act   <= i_duty_sh;
        r_tick       <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign o_cnt         = r_cnt;
  assign o_pwm         = r_pwm;
  assign o_period_tick = r_tick;

endmodule

// File: rtl/pwm_slave.sv
// PWM bus slave: register decode, period/duty shadows, pending flag and registered readback.
module pwm_slave
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_slave_if.slave   bus,
  output logic         pwm,
  output logic         period_tick
);

  logic             r_en;
  logic [CNT_W-1:0] r_period_sh;
  logic [CNT_W-1:0] r_duty_sh;
  logic             r_pending;
  logic [31:0]      r_dout;

  logic             w_wr;
  logic             w_rd;
  logic [1:0]       w_idx;
  logic [CNT_W-1:0] w_cnt;
  logic             w_load;
  logic [31:0]      w_rdata;
  logic             w_unused_adr;

  assign w_wr  = bus.cs && bus.wr;
  assign w_rd  = bus.cs && bus.rd && !bus.wr;
  assign w_idx = bus.adr[3:2];

  assign w_unused_adr = ^{bus.adr[31:4], bus.adr[1:0]};

  if (CNT_W < 32) begin : g_narrow
    logic w_unused_din;
    assign w_unused_din = ^bus.d_in[31:CNT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= 1'b0;
      r_period_sh <= '0;
      r_duty_sh   <= '0;
    end else if (w_wr) begin
      case (w_idx)
        REG_CTRL:   r_en        <= bus.d_in[CTRL_EN];
        REG_PERIOD: r_period_sh <= bus.d_in[CNT_W-1:0];
        REG_DUTY:   r_duty_sh   <= bus.d_in[CNT_W-1:0];
        default:    ;
      endcase
    end
  end

  // A shadow write on the same edge as a load wins, so the new value stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (w_wr && (w_idx == REG_PERIOD || w_idx == REG_DUTY)) begin
      r_pending <= 1'b1;
    end else if (w_load) begin
      r_pending <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL: begin
        w_rdata[CTRL_EN]   = r_en;
        w_rdata[CTRL_PEND] = r_pending;
      end
      REG_PERIOD: w_rdata = 32'(r_period_sh);
      REG_DUTY:   w_rdata = 32'(r_duty_sh);
      default:    w_rdata = 32'(w_cnt);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_rd) begin
      r_dout <= w_rdata;
    end
  end

  assign bus.d_out = r_dout;

  pwm_core #(.CNT_W(CNT_W)) u_core (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (r_en),
    .i_period_sh   (r_period_sh),
    .i_duty_sh     (r_duty_sh),
    .o_cnt         (w_cnt),
    .o_pwm         (pwm),
    .o_period_tick (period_tick),
    .o_load        (w_load)
  );

endmodule

// File: tb/tb_pwm_slave.sv
// Directed and randomized checks of pwm_slave against a cycle-level behavioural model.
module tb_pwm_slave;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic pwm;
  logic period_tick;
  int   checks   = 0;
  int   failures = 0;

  pwm_slave_if bus_if ();

  pwm_slave #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .pwm         (pwm),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic        m_en, m_pend, m_pwm, m_tick;
  logic [31:0] m_ps, m_ds, m_pa, m_da, m_cnt, m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_pwm = 0; m_tick = 0;
    m_ps = 0; m_ds = 0; m_pa = 0; m_da = 0; m_cnt = 0; m_dout = 0;
  endtask

  task automatic model_step(input logic cs, wr, rd, input logic [31:0] adr, d);
    logic [1:0] idx;
    logic       wfire, rfire, last, loaded;
    logic [31:0] rdv;
    idx   = adr[3:2];
    wfire = cs & wr;
    rfire = cs & rd & ~wr;
    case (idx)
      2'd0:    rdv = {30'd0, m_pend, m_en};
      2'd1:    rdv = m_ps;
      2'd2:    rdv = m_ds;
      default: rdv = m_cnt;
    endcase
    if (rfire) m_dout = rdv;
    // The counter covers positions 0..period-1; the last position ends the period.
    last = (longint'(m_cnt) + 1) >= longint'(m_pa);
    if (!m_en) begin
      loaded = 1; m_cnt = 0; m_pwm = 0; m_tick = 0; m_pa = m_ps; m_da = m_ds;
    end else begin
      loaded = last;
      m_pwm  = (m_cnt < m_da);
      m_tick = last;
      if (last) begin m_cnt = 0; m_pa = m_ps; m_da = m_ds; end
      else m_cnt = m_cnt + 1;
    end
    if (wfire && (idx == 2'd1 || idx == 2'd2)) m_pend = 1;
    else if (loaded) m_pend = 0;
    if (wfire) begin
      if (idx == 2'd0) m_en = d[0];
      if (idx == 2'd1) m_ps = d;
      if (idx == 2'd2) m_ds = d;
    end
  endtask

  task automatic bus_cycle(input logic cs, wr, rd, input logic [31:0] adr, d);
    bus_if.cs = cs; bus_if.wr = wr; bus_if.rd = rd; bus_if.adr = adr; bus_if.d_in = d;
    @(posedge clk);
    model_step(cs, wr, rd, adr, d);
    #1;
    chk("pwm", {31'd0, pwm}, {31'd0, m_pwm});
    chk("period_tick", {31'd0, period_tick}, {31'd0, m_tick});
    chk("d_out", bus_if.d_out, m_dout);
  endtask

  task automatic idle();
    bus_cycle(0, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] v);
    bus_cycle(1, 1, 0, {28'd0, idx, 2'b00}, v);
  endtask

  task automatic rd_reg(input logic [1:0] idx);
    bus_cycle(1, 0, 1, {28'd0, idx, 2'b00}, 32'd0);
  endtask

  task automatic idle_count(input int n, output int hi, output int tk);
    hi = 0; tk = 0;
    repeat (n) begin
      idle();
      hi += int'(pwm);
      tk += int'(period_tick);
    end
  endtask

  // Idle until the model's counter is at t before the next edge; bounded.
  task automatic wait_cnt(input logic [31:0] t);
    int n = 0;
    while (m_cnt != t && n < 200) begin idle(); n++; end
    chk("wait_cnt_timeout", m_cnt, t);
  endtask

  initial begin
    int hi, tk;
    logic [31:0] r, v;
    logic [1:0]  idx;
    int op;

    bus_if.cs = 0; bus_if.wr = 0; bus_if.rd = 0; bus_if.adr = 0; bus_if.d_in = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", {31'd0, pwm}, 32'd0);
    chk("rst_tick", {31'd0, period_tick}, 32'd0);
    chk("rst_dout", bus_if.d_out, 32'd0);
    rst_n = 1;

    // Basic 10/3 waveform
    wr_reg(REG_PERIOD, 32'd10);
    wr_reg(REG_DUTY, 32'd3);
    wr_reg(REG_CTRL, 32'd1);
    idle();
    chk("first_pwm_high", {31'd0, pwm}, 32'd1);
    idle_count(20, hi, tk);
    chk("basic_high", hi, 32'd6);
    chk("basic_ticks", tk, 32'd2);
    rd_reg(REG_CNT);
    chk("cnt_range", {31'd0, bus_if.d_out < 32'd10}, 32'd1);
    rd_reg(REG_PERIOD);
    chk("rd_period", bus_if.d_out, 32'd10);

    // Double buffering: duty change mid-period
    wait_cnt(32'd4);
    wr_reg(REG_DUTY, 32'd6);
    rd_reg(REG_CTRL);
    chk("pend_set", bus_if.d_out, 32'd3);
    wait_cnt(32'd9);
    idle();
    idle_count(10, hi, tk);
    chk("dbuf_new_high", hi, 32'd6);
    rd_reg(REG_CTRL);
    chk("pend_clear", bus_if.d_out, 32'd1);

    // Shadow write on the wrap edge
    wait_cnt(32'd9);
    wr_reg(REG_DUTY, 32'd8);
    rd_reg(REG_CTRL);
    chk("pend_across_wrap", bus_if.d_out, 32'd3);
    hi = int'(pwm);
    idle_count(9, v, tk);
    chk("wrap_old_high", hi + v, 32'd6);
    idle_count(10, hi, tk);
    chk("wrap_new_high", hi, 32'd8);

    // Duty boundaries
    wr_reg(REG_DUTY, 32'd0);
    wait_cnt(32'd9); idle();
    idle_count(10, hi, tk);
    chk("duty0_high", hi, 32'd0);
    wr_reg(REG_DUTY, 32'd15);
    wait_cnt(32'd9); idle();
    idle_count(10, hi, tk);
    chk("duty_full_high", hi, 32'd10);
    wr_reg(REG_PERIOD, 32'd1);
    wr_reg(REG_DUTY, 32'd1);
    wait_cnt(32'd9); idle();
    idle_count(5, hi, tk);
    chk("p1_high", hi, 32'd5);
    chk("p1_ticks", tk, 32'd5);

    // Bus corner cases
    wr_reg(REG_PERIOD, 32'd10);
    wr_reg(REG_DUTY, 32'd3);
    idle();
    rd_reg(REG_PERIOD);
    bus_cycle(1, 1, 1, {28'd0, REG_PERIOD, 2'b00}, 32'd20);
    chk("wrrd_dout_held", bus_if.d_out, 32'd10);
    rd_reg(REG_PERIOD);
    chk("wrrd_written", bus_if.d_out, 32'd20);
    wr_reg(REG_CNT, 32'h55);
    bus_cycle(1, 0, 1, 32'h14, 32'd0);
    chk("alias_period", bus_if.d_out, 32'd20);
    wait_cnt(32'd1);
    wr_reg(REG_CTRL, 32'd0);
    chk("dis_pwm", {31'd0, pwm}, 32'd1);
    idle();
    chk("dis_pwm_low", {31'd0, pwm}, 32'd0);
    rd_reg(REG_CNT);
    chk("dis_cnt", bus_if.d_out, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 5));
      r   = $urandom();
      idx = 2'($urandom_range(0, 3));
      case (idx)
        2'd0:    v = {31'd0, 1'($urandom_range(0, 3) != 0)};
        2'd1:    v = $urandom_range(0, 12);
        2'd2:    v = $urandom_range(0, 14);
        default: v = $urandom();
      endcase
      case (op)
        0:       bus_cycle(1, 1, 0, {r[31:4], idx, r[1:0]}, v);
        1, 2:    bus_cycle(1, 0, 1, {r[31:4], idx, r[1:0]}, v);
        3:       bus_cycle(1, 1, 1, {r[31:4], idx, r[1:0]}, v);
        default: bus_cycle(r[0], r[1], r[2] & ~r[0], r, v);
      endcase
    end

    // Asynchronous reset while running
    wr_reg(REG_PERIOD, 32'd6);
    wr_reg(REG_DUTY, 32'd4);
    wr_reg(REG_CTRL, 32'd1);
    idle(); idle();
    rd_reg(REG_PERIOD);
    chk("pre_rst_dout", bus_if.d_out, 32'd6);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_pwm", {31'd0, pwm}, 32'd0);
    chk("async_rst_tick", {31'd0, period_tick}, 32'd0);
    chk("async_rst_dout", bus_if.d_out, 32'd0);
    bus_if.cs = 0; bus_if.wr = 0; bus_if.rd = 0;
    @(posedge clk);
    #1 rst_n = 1;
    rd_reg(REG_CTRL);
    chk("post_rst_ctrl", bus_if.d_out, 32'd0);
    rd_reg(REG_CNT);
    chk("post_rst_cnt", bus_if.d_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
